// File: rtl/rv32i_types.sv
// Shared RV32I memory-side types: word type, arbiter state, grant encoding, captured request.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  typedef struct packed {
    logic [3:0] be;
    rv32i_word  addr;
    rv32i_word  wdata;
  } mem_req_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data requesters.
// Latency: grant to mem strobe 1 cycle, mem_resp to requester resp 0 cycles; requesters hold their level until resp.
module mem_port_arbiter
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  rv32i_word  i_address,
  output logic       i_resp,
  output rv32i_word  i_rdata,
  input  logic       d_read,
  input  logic       d_write,
  input  logic [3:0] d_byte_enable,
  input  rv32i_word  d_address,
  input  rv32i_word  d_wdata,
  output logic       d_resp,
  output rv32i_word  d_rdata,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output rv32i_word  mem_address,
  output rv32i_word  mem_wdata,
  input  logic       mem_resp,
  input  rv32i_word  mem_rdata
);

  arb_state_t state;
  arb_grant_t last_grant;
  mem_req_t   cap;
  logic       d_req;
  logic       pick_i;

  // On a tie the side that did not win the previous transaction goes first.
  always_comb begin
    d_req  = d_read | d_write;
    pick_i = i_read & (~d_req | (last_grant == GRANT_D));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_D;
      cap        <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_i) begin
            state    <= ARB_SERVE_I;
            cap      <= '{be: BE_ALL, addr: i_address, wdata: 32'h0};
            mem_read <= 1'b1;
          end else if (d_req) begin
            // A simultaneous read+write is treated as a write.
            state     <= ARB_SERVE_D;
            cap       <= '{be: d_write ? d_byte_enable : BE_ALL, addr: d_address, wdata: d_wdata};
            mem_read  <= ~d_write;
            mem_write <= d_write;
          end
        end
        ARB_SERVE_I: begin
          if (mem_resp) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
          end
        end
        ARB_SERVE_D: begin
          if (mem_resp) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_D;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_byte_enable = cap.be;
  assign mem_address     = cap.addr;
  assign mem_wdata       = cap.wdata;

  always_comb begin
    i_resp  = (state == ARB_SERVE_I) & mem_resp;
    d_resp  = (state == ARB_SERVE_D) & mem_resp;
    i_rdata = i_resp ? mem_rdata : 32'h0;
    d_rdata = d_resp ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import rv32i_types::*;

  localparam int SIDE_NONE = 0;
  localparam int SIDE_I    = 1;
  localparam int SIDE_D    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_read, i_resp;
  rv32i_word  i_address, i_rdata;
  logic       d_read, d_write, d_resp;
  logic [3:0] d_byte_enable;
  rv32i_word  d_address, d_wdata, d_rdata;
  logic       mem_read, mem_write, mem_resp;
  logic [3:0] mem_byte_enable;
  rv32i_word  mem_address, mem_wdata, mem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
    else $error("illegal stimulus: d_read and d_write together");

  typedef struct { bit wr; logic [3:0] be; rv32i_word addr; rv32i_word wdata; int cyc; } txn_t;
  typedef struct { int side; rv32i_word rdata; } rsp_t;

  txn_t exp_mem_q[$];
  rsp_t exp_rsp_q[$];
  int   grant_log[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Requester-side intent, the reference model and the memory responder.
  bit        i_pend, d_pend, d_wr_v;
  rv32i_word i_addr_v, d_addr_v, d_wd_v;
  logic [3:0] d_be_v;
  bit        m_busy, m_free_next;
  int        m_owner, m_last, busy_cnt;
  bit        mem_inflight, act_seen, stray_req, rnd_mode, continuous, rdata_force_en;
  int        mem_wait, mem_min_delay, mem_max_delay;
  rv32i_word rdata_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic new_fields(input int side);
    if (side == SIDE_I) i_addr_v = $urandom;
    else begin
      d_wr_v   = 1'($urandom_range(1, 0));
      d_be_v   = 4'($urandom_range(15, 1));
      d_addr_v = $urandom;
      d_wd_v   = $urandom;
    end
  endtask

  task automatic drive_pins();
    i_read        = i_pend;
    i_address     = i_addr_v;
    d_read        = d_pend && !d_wr_v;
    d_write       = d_pend && d_wr_v;
    d_byte_enable = d_be_v;
    d_address     = d_addr_v;
    d_wdata       = d_wd_v;
  endtask

  task automatic step();
    @(posedge clk); #1;
    rst = 1'b0;
    if (m_free_next) begin
      m_free_next = 1'b0;
      m_busy      = 1'b0;
      if (m_owner == SIDE_I) i_pend = continuous; else d_pend = continuous;
      if (continuous) new_fields(m_owner);
    end
    // Memory: answer each observed transaction after a random delay.
    mem_resp  = 1'b0;
    mem_rdata = '0;
    if (!mem_inflight && act_seen) begin
      mem_inflight = 1'b1;
      mem_wait     = $urandom_range(mem_max_delay, mem_min_delay);
    end
    if (mem_inflight) begin
      if (mem_wait == 0) begin
        mem_inflight = 1'b0;
        mem_resp     = 1'b1;
        mem_rdata    = rdata_force_en ? rdata_force : $urandom;
        exp_rsp_q.push_back('{m_busy ? m_owner : SIDE_NONE, mem_rdata});
        if (m_busy) begin
          m_last      = m_owner;
          m_free_next = 1'b1;
        end
      end else mem_wait--;
    end else if (stray_req && !m_busy) begin
      stray_req = 1'b0;
      mem_resp  = 1'b1;
      mem_rdata = $urandom;
      exp_rsp_q.push_back('{SIDE_NONE, mem_rdata});
    end
    if (rnd_mode) begin
      if (!i_pend) begin
        if ($urandom_range(2, 0) == 0) begin i_pend = 1'b1; new_fields(SIDE_I); end
      end else if (!(m_busy && m_owner == SIDE_I)) begin
        if ($urandom_range(9, 0) == 0) i_pend = 1'b0;
      end else i_addr_v = $urandom;
      if (!d_pend) begin
        if ($urandom_range(2, 0) == 0) begin d_pend = 1'b1; new_fields(SIDE_D); end
      end else if (!(m_busy && m_owner == SIDE_D)) begin
        if ($urandom_range(9, 0) == 0) d_pend = 1'b0;
      end else begin
        d_addr_v = $urandom; d_wd_v = $urandom; d_be_v = 4'($urandom);
      end
      if (!m_busy && $urandom_range(7, 0) == 0) stray_req = 1'b1;
    end
    // Reference: a free port goes to the lone requester, or on a tie to the side not served last.
    if (!m_busy && (i_pend || d_pend)) begin
      if (i_pend && d_pend) m_owner = (m_last == SIDE_I) ? SIDE_D : SIDE_I;
      else                  m_owner = i_pend ? SIDE_I : SIDE_D;
      if (m_owner == SIDE_I) exp_mem_q.push_back('{1'b0, 4'b1111, i_addr_v, 32'h0, cyc});
      else exp_mem_q.push_back('{d_wr_v, d_wr_v ? d_be_v : 4'b1111, d_addr_v, d_wd_v, cyc});
      m_busy   = 1'b1;
      busy_cnt = 0;
    end else if (m_busy && ++busy_cnt > 60) begin
      n_total++;
      $display("FAIL grant_timeout: side %0d got no completion within 60 cycles", m_owner);
      m_busy = 1'b0; m_free_next = 1'b0;
      if (m_owner == SIDE_I) i_pend = 1'b0; else d_pend = 1'b0;
    end
    drive_pins();
    @(negedge clk);
    act_seen = (mem_read || mem_write) && !mem_resp;
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      i_pend = 1'b0; d_pend = 1'b0; m_busy = 1'b0; m_free_next = 1'b0; m_last = SIDE_D;
      mem_inflight = 1'b0; stray_req = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
      drive_pins();
      @(negedge clk);
      act_seen = 1'b0;
    end
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_resp", 32'({i_resp, d_resp}), 32'd0);
  endtask

  task automatic run_until_quiet(input int max);
    int k;
    for (k = 0; k < max; k++) begin
      step();
      if (!m_busy && !i_pend && !d_pend && !mem_inflight) break;
    end
    if (k == max) begin
      n_total++;
      $display("FAIL quiet_timeout: still busy after %0d cycles (busy=%0d)", max, m_busy);
    end
    step();
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin : monitor
    txn_t cur;
    rsp_t r;
    bit   prev_act = 1'b0;
    bit   cur_ok   = 1'b0;
    forever begin
      @(negedge clk);
      check("resp_exclusive", 32'(i_resp & d_resp), 32'd0);
      if (mem_resp) begin
        if (exp_rsp_q.size() == 0) begin
          n_total++;
          $display("FAIL rsp_underflow: mem_resp with nothing expected at %0t", $time);
        end else begin
          r = exp_rsp_q.pop_front();
          check("i_resp", 32'(i_resp), 32'(r.side == SIDE_I));
          check("d_resp", 32'(d_resp), 32'(r.side == SIDE_D));
          if (r.side == SIDE_I) check("i_rdata", i_rdata, r.rdata);
          if (r.side == SIDE_D) check("d_rdata", d_rdata, r.rdata);
        end
      end else begin
        check("resp_without_mem_resp", 32'({i_resp, d_resp}), 32'd0);
        check("rdata_idle_zero", i_rdata | d_rdata, 32'd0);
      end
      if (i_resp) grant_log.push_back(SIDE_I);
      if (d_resp) grant_log.push_back(SIDE_D);
      if (mem_read || mem_write) begin
        if (!prev_act) begin
          cur_ok = exp_mem_q.size() != 0;
          if (cur_ok) begin
            cur = exp_mem_q.pop_front();
            check("grant_cycle", cyc, cur.cyc + 1);
          end else begin
            n_total++;
            $display("FAIL unexpected_txn: addr 0x%08h at %0t", mem_address, $time);
          end
        end
        if (cur_ok) begin
          check("mem_write", 32'(mem_write), 32'(cur.wr));
          check("mem_read", 32'(mem_read), 32'(!cur.wr));
          check("mem_byte_enable", 32'(mem_byte_enable), 32'(cur.be));
          check("mem_address", mem_address, cur.addr);
          if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
        end
      end
      prev_act = (mem_read || mem_write) && !mem_resp;
    end
  end

  initial begin : stimulus
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = '0;
    i_addr_v = '0; d_addr_v = '0; d_wd_v = '0; d_be_v = '0; d_wr_v = 1'b0;
    rnd_mode = 1'b0; continuous = 1'b0; rdata_force_en = 1'b0; rdata_force = '0;
    mem_min_delay = 0; mem_max_delay = 3; m_owner = SIDE_NONE;
    do_reset(3);

    // Lone instruction fetch with a fixed response word.
    rdata_force_en = 1'b1; rdata_force = 32'h0000_0013; mem_max_delay = 0;
    i_pend = 1'b1; i_addr_v = 32'h60;
    run_until_quiet(30);
    rdata_force_en = 1'b0; mem_max_delay = 3;

    // Tie right after reset: fetch first, then the byte-masked write.
    do_reset(2);
    grant_log.delete();
    i_pend = 1'b1; i_addr_v = 32'h400;
    d_pend = 1'b1; d_wr_v = 1'b1; d_addr_v = 32'h100; d_wd_v = 32'hDEAD_BEEF; d_be_v = 4'b0011;
    run_until_quiet(40);
    check("tie_order_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("tie_first", grant_log[0], SIDE_I);
      check("tie_second", grant_log[1], SIDE_D);
    end

    // Both sides requesting back to back must alternate.
    grant_log.delete();
    continuous = 1'b1;
    i_pend = 1'b1; new_fields(SIDE_I);
    d_pend = 1'b1; new_fields(SIDE_D);
    for (int k = 0; k < 200 && grant_log.size() < 6; k++) step();
    continuous = 1'b0;
    run_until_quiet(40);
    check("alt_count", 32'(grant_log.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < grant_log.size(); k++)
      check("alt_order", grant_log[k], (k % 2 == 0) ? SIDE_I : SIDE_D);

    // Address change after grant must not leak downstream.
    mem_min_delay = 2;
    d_pend = 1'b1; d_wr_v = 1'b0; d_addr_v = 32'h200; d_be_v = 4'b0101;
    step();
    d_addr_v = 32'h300;
    run_until_quiet(40);
    mem_min_delay = 0;

    // Reset with a write outstanding, then a late completion.
    mem_min_delay = 8; mem_max_delay = 8;
    d_pend = 1'b1; d_wr_v = 1'b1; d_addr_v = 32'h880; d_wd_v = 32'h1234_5678; d_be_v = 4'b1100;
    repeat (4) step();
    do_reset(2);
    mem_min_delay = 0; mem_max_delay = 3;
    stray_req = 1'b1;
    repeat (2) step();

    // Stray completion while idle, then a normal fetch still gets its usual timing.
    stray_req = 1'b1;
    repeat (2) step();
    i_pend = 1'b1; i_addr_v = 32'h0000_0abc;
    run_until_quiet(30);

    // Randomized traffic with drops, strays and post-grant input churn.
    rnd_mode = 1'b1;
    repeat (2000) step();
    rnd_mode = 1'b0;
    if (!(m_busy && m_owner == SIDE_I)) i_pend = 1'b0;
    if (!(m_busy && m_owner == SIDE_D)) d_pend = 1'b0;
    run_until_quiet(100);
    repeat (2) step();

    check("exp_mem_left", exp_mem_q.size(), 0);
    check("exp_rsp_left", exp_rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
